// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Handshake and control bundle between the pipeline scheduler
//               and the fetch, data-bus, hazard and exception sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             inst_req_i;
    logic             inst_ok_i;
    logic             data_req_i;
    logic             data_ok_i;
    logic             id_stall_req_i;
    logic             exe_stall_req_i;
    logic             exception_i;
    logic [31:0]      exception_target_i;
    logic [3:0]       stall_o;
    logic             fetch_allow_o;
    logic             inst_discard_o;
    logic             flush_o;
    logic [31:0]      flush_pc_o;
    logic [CNT_W-1:0] outstanding_o;

    // Drives the scheduler's inputs and observes its outputs.
    modport master (
        output inst_req_i, inst_ok_i, data_req_i, data_ok_i,
        output id_stall_req_i, exe_stall_req_i, exception_i, exception_target_i,
        input  stall_o, fetch_allow_o, inst_discard_o, flush_o, flush_pc_o,
        input  outstanding_o
    );

    // The scheduler itself.
    modport slave (
        input  inst_req_i, inst_ok_i, data_req_i, data_ok_i,
        input  id_stall_req_i, exe_stall_req_i, exception_i, exception_target_i,
        output stall_o, fetch_allow_o, inst_discard_o, flush_o, flush_pc_o,
        output outstanding_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline scheduler: stall vector, exception flush
//               with redirect PC, and in-flight fetch tracking/discard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int OUTSTANDING_MAX = 2,
    parameter int CNT_W           = 2
) (
    input  wire logic    clock_i,
    input  wire logic    reset_i,
    pipe_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_max  = CNT_W'(OUTSTANDING_MAX);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard_cnt;
    logic             r_flush;
    logic [31:0]      r_flush_pc;
    logic             r_exc_pending;
    logic [31:0]      r_exc_target;

    logic             w_fetch_allow;
    logic             w_inst_discard;
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] w_outstanding_nxt;
    logic [CNT_W-1:0] w_discard_nxt;
    logic             w_exc_run;
    logic             w_exc_dwait;
    logic             w_flush_enter;
    logic [31:0]      w_flush_target;
    logic [3:0]       w_stall;

    assign w_fetch_allow  = (r_state == ST_RUN) && (r_outstanding < c_max) && !r_exc_pending;
    assign w_inst_discard = bus.inst_ok_i && (r_discard_cnt != c_zero);

    // Discarded returns belong to discard_cnt, never to the live outstanding count.
    assign w_inc = bus.inst_req_i && w_fetch_allow;
    assign w_dec = bus.inst_ok_i && !w_inst_discard && (r_outstanding != c_zero);

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_inc && !w_dec) begin
            w_outstanding_nxt = r_outstanding + c_one;
        end else if (w_dec && !w_inc) begin
            w_outstanding_nxt = r_outstanding - c_one;
        end
    end

    assign w_discard_nxt = w_inst_discard ? (r_discard_cnt - c_one) : r_discard_cnt;

    // An exception in DWAIT is only acted on once the bus transaction completes.
    assign w_exc_run     = (r_state == ST_RUN) && bus.exception_i && !r_flush;
    assign w_exc_dwait   = (r_state == ST_DWAIT) && bus.data_ok_i &&
                           (r_exc_pending || bus.exception_i);
    assign w_flush_enter = w_exc_run || w_exc_dwait;

    always_comb begin
        w_flush_target = bus.exception_target_i;
        if ((r_state == ST_DWAIT) && r_exc_pending) begin
            w_flush_target = r_exc_target;
        end
    end

    always_comb begin
        w_stall    = 4'b0000;
        w_stall[3] = (r_state == ST_DWAIT) && !bus.data_ok_i;
        w_stall[2] = bus.exe_stall_req_i || w_stall[3];
        w_stall[1] = bus.id_stall_req_i  || w_stall[2];
        w_stall[0] = !w_stall[1] && !(bus.inst_ok_i && !w_inst_discard);
        if (r_flush) begin
            w_stall = 4'b0000;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state       <= ST_RUN;
            r_outstanding <= c_zero;
            r_discard_cnt <= c_zero;
            r_flush       <= 1'b0;
            r_flush_pc    <= 32'h0000_0000;
            r_exc_pending <= 1'b0;
            r_exc_target  <= 32'h0000_0000;
        end else begin
            r_flush <= w_flush_enter;
            if (w_flush_enter) begin
                // Fetches still in flight at the flush become discard work.
                r_flush_pc    <= w_flush_target;
                r_discard_cnt <= w_outstanding_nxt;
                r_outstanding <= c_zero;
                r_exc_pending <= 1'b0;
            end else begin
                r_discard_cnt <= w_discard_nxt;
                r_outstanding <= w_outstanding_nxt;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_exc_run) begin
                        r_state <= ST_FLUSH;
                    end else if (bus.data_req_i) begin
                        r_state <= ST_DWAIT;
                    end
                end
                ST_DWAIT: begin
                    if (bus.data_ok_i) begin
                        r_state <= w_exc_dwait ? ST_FLUSH : ST_RUN;
                    end else if (bus.exception_i && !r_exc_pending) begin
                        r_exc_pending <= 1'b1;
                        r_exc_target  <= bus.exception_target_i;
                    end
                end
                ST_FLUSH: begin
                    if (w_discard_nxt == c_zero) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.fetch_allow_o  = w_fetch_allow;
    assign bus.inst_discard_o = w_inst_discard;
    assign bus.flush_o        = r_flush;
    assign bus.flush_pc_o     = r_flush_pc;
    assign bus.outstanding_o  = r_outstanding;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for the pipeline scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    pipe_ctrl_if #(.CNT_W(2)) bus ();

    pipe_ctrl #(
        .OUTSTANDING_MAX (2),
        .CNT_W           (2)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        @(negedge clock_i);
    endtask

    task automatic test_reset();
        step(); step();
        reset_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 4'b0001) begin errors++; $display("FAIL reset_stall: got %b expected 0001", bus.stall_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", bus.outstanding_o); end
        checks++; if (bus.fetch_allow_o !== 1'b1) begin errors++; $display("FAIL reset_fetch_allow: got %b expected 1", bus.fetch_allow_o); end
        checks++; if (bus.flush_o !== 1'b0 || bus.flush_pc_o !== 32'h0) begin errors++; $display("FAIL reset_flush: got %b/%h expected 0/00000000", bus.flush_o, bus.flush_pc_o); end
        bus.data_req_i = 1'b1;
        step();
        bus.data_req_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 4'b1110) begin errors++; $display("FAIL pre_reset_dwait_stall: got %b expected 1110", bus.stall_o); end
        reset_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 4'b0001) begin errors++; $display("FAIL async_reset_stall: got %b expected 0001", bus.stall_o); end
        step();
        reset_i = 1'b1;
        bus.inst_ok_i = 1'b1;   // a stray return at count 0 is ignored and not a bubble
        #1;
        checks++; if (bus.stall_o !== 4'b0000) begin errors++; $display("FAIL post_reset_stall: got %b expected 0000", bus.stall_o); end
        checks++; if (bus.fetch_allow_o !== 1'b1) begin errors++; $display("FAIL post_reset_fetch_allow: got %b expected 1", bus.fetch_allow_o); end
        step();
        bus.inst_ok_i = 1'b0;
        #1;
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL ok_at_zero: got %0d expected 0", bus.outstanding_o); end
    endtask

    task automatic test_outstanding();
        bus.inst_req_i = 1'b1;
        step(); #1;
        checks++; if (bus.outstanding_o !== 2'd1 || bus.fetch_allow_o !== 1'b1) begin errors++; $display("FAIL outst_req1: got %0d/%b expected 1/1", bus.outstanding_o, bus.fetch_allow_o); end
        step(); #1;
        checks++; if (bus.outstanding_o !== 2'd2 || bus.fetch_allow_o !== 1'b0) begin errors++; $display("FAIL outst_req2: got %0d/%b expected 2/0", bus.outstanding_o, bus.fetch_allow_o); end
        step(); #1;
        checks++; if (bus.outstanding_o !== 2'd2) begin errors++; $display("FAIL outst_req3: got %0d expected 2", bus.outstanding_o); end
        bus.inst_req_i = 1'b0;
        bus.inst_ok_i  = 1'b1;
        step(); #1;
        checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL outst_ret1: got %0d expected 1", bus.outstanding_o); end
        bus.inst_req_i = 1'b1;
        step(); #1;
        checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL outst_req_and_ret: got %0d expected 1", bus.outstanding_o); end
        bus.inst_req_i = 1'b0;
        step(); #1;
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL outst_drain: got %0d expected 0", bus.outstanding_o); end
        bus.inst_ok_i = 1'b0;
    endtask

    task automatic test_dwait();
        bus.data_req_i = 1'b1;
        step();
        bus.data_req_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (bus.stall_o !== 4'b1110) begin errors++; $display("FAIL dwait_stall_c%0d: got %b expected 1110", c, bus.stall_o); end
            step();
        end
        bus.data_ok_i = 1'b1;
        bus.inst_ok_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 4'b0000) begin errors++; $display("FAIL dwait_done_stall: got %b expected 0000", bus.stall_o); end
        step();
        bus.data_ok_i = 1'b0;
        bus.inst_ok_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 4'b0001 || bus.fetch_allow_o !== 1'b1) begin errors++; $display("FAIL dwait_back_to_run: got %b/%b expected 0001/1", bus.stall_o, bus.fetch_allow_o); end
    endtask

    task automatic test_flush();
        bus.inst_req_i = 1'b1;
        step(); step();
        bus.inst_req_i         = 1'b0;
        bus.exception_i        = 1'b1;
        bus.exception_target_i = 32'hBFC0_0380;
        step();
        bus.exception_i        = 1'b0;
        bus.exception_target_i = 32'h0;
        #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.flush_pc_o !== 32'hBFC0_0380) begin errors++; $display("FAIL flush_pulse: got %b/%h expected 1/bfc00380", bus.flush_o, bus.flush_pc_o); end
        checks++; if (bus.stall_o !== 4'b0000 || bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL flush_stall_outst: got %b/%0d expected 0000/0", bus.stall_o, bus.outstanding_o); end
        step();
        bus.inst_ok_i = 1'b1;
        #1;
        checks++; if (bus.flush_o !== 1'b0 || bus.inst_discard_o !== 1'b1) begin errors++; $display("FAIL flush_discard1: got %b/%b expected 0/1", bus.flush_o, bus.inst_discard_o); end
        checks++; if (bus.stall_o !== 4'b0001) begin errors++; $display("FAIL flush_discard_bubble: got %b expected 0001", bus.stall_o); end
        step(); #1;
        checks++; if (bus.inst_discard_o !== 1'b1 || bus.fetch_allow_o !== 1'b0) begin errors++; $display("FAIL flush_discard2: got %b/%b expected 1/0", bus.inst_discard_o, bus.fetch_allow_o); end
        step();
        bus.inst_ok_i = 1'b0;
        #1;
        checks++; if (bus.fetch_allow_o !== 1'b1 || bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL flush_resume: got %b/%0d expected 1/0", bus.fetch_allow_o, bus.outstanding_o); end
    endtask

    task automatic test_dwait_exception();
        bus.data_req_i = 1'b1;
        step();
        bus.data_req_i         = 1'b0;
        bus.exception_i        = 1'b1;
        bus.exception_target_i = 32'h8000_0180;
        step();
        bus.exception_i        = 1'b0;
        bus.exception_target_i = 32'h0;
        #1;
        checks++; if (bus.flush_o !== 1'b0 || bus.fetch_allow_o !== 1'b0) begin errors++; $display("FAIL dexc_deferred: got %b/%b expected 0/0", bus.flush_o, bus.fetch_allow_o); end
        step(); step();
        bus.data_ok_i = 1'b1;
        #1;
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL dexc_at_data_ok: got %b expected 0", bus.flush_o); end
        step();
        bus.data_ok_i = 1'b0;
        #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.flush_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL dexc_pulse: got %b/%h expected 1/80000180", bus.flush_o, bus.flush_pc_o); end
        step(); #1;
        checks++; if (bus.flush_o !== 1'b0 || bus.fetch_allow_o !== 1'b1) begin errors++; $display("FAIL dexc_single_pulse: got %b/%b expected 0/1", bus.flush_o, bus.fetch_allow_o); end
    endtask

    task automatic test_id_stall();
        bus.id_stall_req_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 4'b0010) begin errors++; $display("FAIL id_stall: got %b expected 0010", bus.stall_o); end
        bus.exe_stall_req_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 4'b0110) begin errors++; $display("FAIL exe_stall: got %b expected 0110", bus.stall_o); end
        bus.exe_stall_req_i = 1'b0;
        bus.id_stall_req_i  = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 4'b0001) begin errors++; $display("FAIL id_release: got %b expected 0001", bus.stall_o); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.exception_i        = 1'b1;
        bus.data_req_i         = 1'b1;
        bus.exception_target_i = 32'h0000_1111;
        step();
        bus.data_req_i         = 1'b0;
        bus.exception_target_i = 32'h0000_2222;
        #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.flush_pc_o !== 32'h0000_1111) begin errors++; $display("FAIL exc_wins: got %b/%h expected 1/00001111", bus.flush_o, bus.flush_pc_o); end
        step();
        bus.exception_i = 1'b0;
        #1;
        checks++; if (bus.flush_o !== 1'b0 || bus.flush_pc_o !== 32'h0000_1111) begin errors++; $display("FAIL second_exc_ignored: got %b/%h expected 0/00001111", bus.flush_o, bus.flush_pc_o); end
        checks++; if (bus.stall_o !== 4'b0001 || bus.fetch_allow_o !== 1'b1) begin errors++; $display("FAIL no_dwait_after_exc: got %b/%b expected 0001/1", bus.stall_o, bus.fetch_allow_o); end
        step();
    endtask

    initial begin
        bus.inst_req_i         = 1'b0;
        bus.inst_ok_i          = 1'b0;
        bus.data_req_i         = 1'b0;
        bus.data_ok_i          = 1'b0;
        bus.id_stall_req_i     = 1'b0;
        bus.exe_stall_req_i    = 1'b0;
        bus.exception_i        = 1'b0;
        bus.exception_target_i = 32'h0;
        test_reset();
        test_outstanding();
        test_dwait();
        test_flush();
        test_dwait_exception();
        test_id_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline scheduler for the five-stage core. It generates the 4-bit stall vector consumed by the postif_id, id_exe, exe_mem and mem_wb registers. It also generates the exception flush pulse with its redirect PC, and tracks in-flight instruction fetches so that stale fetch returns are discarded after a flush. It sits beside the fetch unit and the data-bus interface, and drives no datapath itself.

Parameters:
OUTSTANDING_MAX, 2, maximum in-flight instruction fetch requests (1..3).
CNT_W, 2, width of the outstanding and discard counters; must hold OUTSTANDING_MAX.

Ports:
clock_i  in  1  core clock, rising edge.
reset_i  in  1  asynchronous, active-low reset.
inst_req_i  in  1  fetch unit presents a request this cycle.
inst_ok_i  in  1  fetch return valid this cycle (returns arrive in order).
data_req_i  in  1  MEM stage starts a load/store bus transaction this cycle.
data_ok_i  in  1  data bus transaction complete.
id_stall_req_i  in  1  load-use hazard detected in ID.
exe_stall_req_i  in  1  multi-cycle unit in EXE busy.
exception_i  in  1  exception committed in MEM this cycle.
exception_target_i  in  32  redirect PC for exception_i.
stall_o  out  4  {data, exe, id, inst} stall vector; bit0=inst, bit3=data.
fetch_allow_o  out  1  fetch unit may issue; inst_req_i counts only when this is 1.
inst_discard_o  out  1  current inst_ok_i belongs to a flushed fetch; postif must drop it.
flush_o  out  1  one-cycle pipeline flush pulse.
flush_pc_o  out  32  redirect PC, valid while flush_o=1.
outstanding_o  out  CNT_W  current in-flight fetch count.

Behaviour:
- Reset (asynchronous, active-low):
  - state=RUN, both counters=0, flush_o=0, flush_pc_o=0, exc_pending=0.
  - Reset overrides any state mid-transaction.
- Outstanding counter:
  - +1 on inst_req_i&fetch_allow_o.
  - -1 on inst_ok_i when count>0.
  - Both in the same cycle: count unchanged.
  - inst_ok_i at count 0: ignored, count stays 0.
  - Never exceeds OUTSTANDING_MAX.
- fetch_allow_o = (state==RUN) & (outstanding<OUTSTANDING_MAX) & ~exc_pending.
- States:
  - RUN:
    - data_req_i → DWAIT.
    - exception_i → FLUSH.
    - data_req_i and exception_i together: the exception wins; go to FLUSH, data_req ignored.
  - DWAIT:
    - data_ok_i → RUN, or FLUSH if exc_pending.
    - exception_i in DWAIT sets exc_pending and latches the target. Flush is deferred until data_ok_i.
  - FLUSH:
    - Stays while discard_cnt≠0.
    - → RUN on the cycle discard_cnt reaches 0, or immediately if it is already 0.
- Flush entry (registered, cycle after exception accepted):
  - flush_o=1 for exactly one cycle; flush_pc_o=latched target.
  - discard_cnt := outstanding count after the same-edge update.
  - outstanding := 0. In-flight fetches are tracked only by discard_cnt from this point.
- inst_discard_o = inst_ok_i & (discard_cnt≠0), combinational. Each discarded return decrements discard_cnt.
- Stall vector (combinational, priority downstream-first):
  - stall_o[3] = (state==DWAIT) & ~data_ok_i.
  - stall_o[2] = exe_stall_req_i | stall_o[3].
  - stall_o[1] = id_stall_req_i | stall_o[2].
  - stall_o[0] = ~stall_o[1] & ~(inst_ok_i & ~inst_discard_o). This is a bubble into ID and is asserted only when nothing downstream holds.
  - While flush_o=1, stall_o=4'b0000 so the flush is not masked by a stall.
- exception_i with flush_o already high: second exception ignored.

Test Plan:
1. Reset mid-DWAIT (data_req_i=1, then reset_i=0 for 1 cycle) → stall_o=0000, outstanding_o=0, fetch_allow_o=1 immediately after release.
2. Three inst_req_i pulses with no returns, OUTSTANDING_MAX=2 → outstanding_o=1,2,2; fetch_allow_o=0 after the second request; third request not counted.
3. data_req_i at cycle 0, data_ok_i at cycle 4, exe_stall_req_i=0 → stall_o=1110 for cycles 1–3, 0000 (with inst_ok_i=1) at cycle 4, then RUN.
4. Two fetches outstanding, exception_i with target 32'hBFC00380 → next cycle flush_o=1 and flush_pc_o=BFC00380; the next two inst_ok_i give inst_discard_o=1; fetch_allow_o=1 on the cycle after the second discard.
5. exception_i during DWAIT, data_ok_i 3 cycles later → flush_o stays 0 until the cycle after data_ok_i, then pulses once with the latched target.
6. id_stall_req_i=1 with no inst_ok_i → stall_o=0010 (bit0 suppressed); drop id_stall_req_i → stall_o=0001.
